irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller and CP0-lite register file sitting between the bus devices (timer IRQ on line 0) and the CPU core.
- Registers the device IRQ lines into a pending field and masks them with SR.
- Raises a single request to the CPU, takes the CPU's acknowledge together with the victim PC, and saves EPC.
- Holds off further requests until ERET; registers are bus-accessible through the same slave interface style as the devices.

Parameters:
- NUM_IRQ, 6, number of hardware interrupt lines; IM/IP occupy bits [9+NUM_IRQ:10]
- PRID_VAL, 32'h0000_4D49, constant returned by the PRID register

Ports:
- CLK_I  in  1  system clock; all state on posedge
- RST_I  in  1  asynchronous, active-low reset
- ADD_I  in  [3:2]  register select: 0 SR, 1 CAUSE, 2 EPC, 3 PRID
- WE_I  in  1  bus write strobe, one cycle per write
- DAT_I  in  32  bus write data
- DAT_O  out  32  bus read data, combinational from ADD_I
- HWINT  in  NUM_IRQ  level-high device interrupts; bit 0 = timer IRQ
- INT_ACK  in  1  CPU accepts the interrupt this cycle
- PC_I  in  32  PC of the interrupted instruction, valid with INT_ACK
- ERET  in  1  CPU executing ERET this cycle
- INT_REQ  out  1  interrupt request to CPU
- EPC_O  out  32  current EPC, used as the ERET target

Behaviour:
- Reset (RST_I=0, async):
  - SR, CAUSE and EPC are 0.
  - FSM goes to IDLE.
  - INT_REQ=0; EPC_O=0.
- SR fields:
  - IM[15:10] and IE[0] are RW.
  - EXL[1] is RW by bus, but hardware updates take precedence (see priority rules).
  - All other bits read 0.
- CAUSE fields:
  - IP[15:10] = HWINT registered every cycle; there is no latching, so an IRQ deasserted by the device clears IP next cycle.
  - ExcCode[6:2] is always 0.
  - Bus writes are ignored.
- EPC:
  - RW by bus; bits [1:0] are forced to 0 on every write.
  - On INT_ACK, EPC <= {PC_I[31:2],2'b00}.
- PRID: read-only PRID_VAL; writes ignored.
- Pending term: pend = |(IP & IM) & IE & ~EXL.
- FSM states:
  - IDLE: INT_REQ=0. pend=1 -> REQ.
  - REQ: INT_REQ=1.
    - INT_ACK -> SERVICE; set EXL, save EPC.
    - pend drops without ACK (device cleared, IM/IE cleared, or EXL written 1) -> IDLE; INT_REQ drops in that same transition.
  - SERVICE: INT_REQ=0. ERET -> IDLE and clear EXL.
- INT_REQ is a registered FSM output.
- Latency:
  - HWINT rise -> IP set: +1 cycle.
  - IP set -> INT_REQ high: +1 cycle, so 2 cycles from HWINT to INT_REQ.
  - INT_ACK -> INT_REQ low and EXL=1 on the next edge.
- Priority and boundary rules:
  - INT_ACK while not in REQ: ignored; EPC and EXL are unchanged.
  - ERET outside SERVICE: clears EXL only (supports software-set EXL); no FSM change.
  - Bus write to SR in the same cycle as INT_ACK: IM/IE come from DAT_I, and EXL=1.
  - Bus write to SR in the same cycle as ERET in SERVICE: EXL=0, other bits from DAT_I.
  - Bus write to EPC in the same cycle as INT_ACK: the hardware EPC value wins.
  - Bus write to EPC during SERVICE is allowed and changes EPC_O the next cycle.
  - After ERET, if pend is still true, REQ is re-entered 1 cycle later (back-to-back interrupts).
  - Multiple lines pending: one request covers all; software reads IP to dispatch.
  - Reset mid-SERVICE: immediate return to IDLE with EXL=0.
- DAT_O reflects register state after the previous edge; a write is visible on read the following cycle.

Test Plan:
- Reset release, read all four addresses -> SR=0, CAUSE=0, EPC=0, PRID=32'h0000_4D49; INT_REQ=0.
- Write SR=32'h0000_0401 (IM0, IE), pulse HWINT[0] high and hold -> CAUSE=32'h0000_0400 after 1 cycle; INT_REQ=1 after 2 cycles.
- Then INT_ACK with PC_I=32'h0000_3007 -> EPC_O=32'h0000_3004; SR reads 32'h0000_0403; INT_REQ=0.
- Then ERET with HWINT[0] still high -> EXL=0; INT_REQ=1 one cycle later.
- HWINT[3]=1 with IM3=0, IE=1 -> IP bit 13 set, INT_REQ stays 0. Then write SR=32'h0000_2001 -> INT_REQ=1 one cycle after the write.
- In REQ, drop HWINT[0] before any ACK -> INT_REQ falls within 2 cycles; EPC unchanged.
- In SERVICE, assert RST_I=0 asynchronously mid-cycle -> SR, EPC and INT_REQ are 0 immediately; stays in IDLE after release.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// Register bus between a bus master and the irq_ctrl register file.
//   ADD_I  register select (word address [3:2])
//   WE_I   single-cycle write strobe
//   DAT_I  write data
//   DAT_O  read data, combinational from ADD_I
interface irq_ctrl_if;
  logic [3:2]  ADD_I;
  logic        WE_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;

  modport master (output ADD_I, output WE_I, output DAT_I, input DAT_O);
  modport slave  (input ADD_I, input WE_I, input DAT_I, output DAT_O);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller with a small CP0-style register file (SR, CAUSE, EPC, PRID).
// Samples device IRQ lines into CAUSE.IP, masks them with SR.IM/IE/EXL, raises a
// single request to the CPU, saves EPC on acknowledge and holds off until ERET.
//   CLK_I    system clock
//   RST_I    asynchronous active-low reset
//   bus      register bus slave (0 SR, 1 CAUSE, 2 EPC, 3 PRID)
//   HWINT    level-high device interrupts, bit 0 = timer
//   INT_ACK  CPU takes the interrupt this cycle, PC_I holds the victim PC
//   ERET     CPU executes ERET this cycle
//   INT_REQ  registered interrupt request to the CPU
//   EPC_O    current EPC (ERET target)
module irq_ctrl #(
  parameter int unsigned NUM_IRQ  = 6,
  parameter logic [31:0] PRID_VAL = 32'h0000_4D49
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  irq_ctrl_if.slave          bus,
  input  logic [NUM_IRQ-1:0] HWINT,
  input  logic               INT_ACK,
  input  logic [31:0]        PC_I,
  input  logic               ERET,
  output logic               INT_REQ,
  output logic [31:0]        EPC_O
);

  localparam int unsigned IM_LO = 10;
  localparam int unsigned IM_HI = IM_LO + NUM_IRQ - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               int_req_q, int_req_d;
  logic [NUM_IRQ-1:0] im_q, ip_q;
  logic               ie_q, exl_q;
  logic [31:0]        epc_q;
  logic               pend;
  logic               take_irq, clr_exl;
  logic               sr_wr, epc_wr;
  logic [31:0]        sr_rd, cause_rd;

  assign pend   = (|(ip_q & im_q)) & ie_q & ~exl_q;
  assign sr_wr  = bus.WE_I && (bus.ADD_I == 2'd0);
  assign epc_wr = bus.WE_I && (bus.ADD_I == 2'd2);

  // State register; INT_REQ is registered alongside it
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q   <= IDLE;
      int_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      int_req_q <= int_req_d;
    end
  end

  // Next-state logic; acknowledge wins over a pend drop in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pend) state_d = REQ;
      REQ: begin
        if (INT_ACK)   state_d = SERVICE;
        else if (!pend) state_d = IDLE;
      end
      SERVICE: if (ERET) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request is the registered copy of "next state is REQ"
  always_comb begin
    int_req_d = 1'b0;
    take_irq  = 1'b0;
    clr_exl   = 1'b0;
    int_req_d = (state_d == REQ);
    take_irq  = (state_q == REQ) && INT_ACK;
    // ERET clears EXL in any state so software-set EXL can be undone
    clr_exl   = ERET && !take_irq;
  end

  // Register file; hardware EXL/EPC updates take precedence over bus writes
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ip_q  <= '0;
      im_q  <= '0;
      ie_q  <= 1'b0;
      exl_q <= 1'b0;
      epc_q <= '0;
    end else begin
      ip_q <= HWINT;
      if (sr_wr) begin
        im_q <= bus.DAT_I[IM_HI:IM_LO];
        ie_q <= bus.DAT_I[0];
      end
      if (take_irq)     exl_q <= 1'b1;
      else if (clr_exl) exl_q <= 1'b0;
      else if (sr_wr)   exl_q <= bus.DAT_I[1];
      if (take_irq)    epc_q <= PC_I & ~32'h3;
      else if (epc_wr) epc_q <= bus.DAT_I & ~32'h3;
    end
  end

  // Read mux; unimplemented bits read as zero
  always_comb begin
    sr_rd              = '0;
    cause_rd           = '0;
    bus.DAT_O          = '0;
    sr_rd[IM_HI:IM_LO] = im_q;
    sr_rd[1]           = exl_q;
    sr_rd[0]           = ie_q;
    cause_rd[IM_HI:IM_LO] = ip_q;
    case (bus.ADD_I)
      2'd0:    bus.DAT_O = sr_rd;
      2'd1:    bus.DAT_O = cause_rd;
      2'd2:    bus.DAT_O = epc_q;
      default: bus.DAT_O = PRID_VAL;
    endcase
  end

  assign INT_REQ = int_req_q;
  assign EPC_O   = epc_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: each scenario pushes expected values as it drives
// stimulus, pushes observed values as the DUT produces them, then compares in order.
module tb_irq_ctrl;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [5:0]  HWINT;
  logic        INT_ACK;
  logic [31:0] PC_I;
  logic        ERET;
  logic        INT_REQ;
  logic [31:0] EPC_O;

  irq_ctrl_if bus_if ();

  irq_ctrl #(.NUM_IRQ(6), .PRID_VAL(32'h0000_4D49)) dut (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .bus     (bus_if),
    .HWINT   (HWINT),
    .INT_ACK (INT_ACK),
    .PC_I    (PC_I),
    .ERET    (ERET),
    .INT_REQ (INT_REQ),
    .EPC_O   (EPC_O)
  );

  always #5 CLK_I = ~CLK_I;

  int checks   = 0;
  int failures = 0;

  string       exp_tag[$];
  logic [31:0] exp_val[$];
  logic [31:0] obs_val[$];

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_tag.push_back(tag);
    exp_val.push_back(v);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.ADD_I = a;
    bus_if.WE_I  = 1'b1;
    bus_if.DAT_I = d;
    tick();
    bus_if.WE_I  = 1'b0;
  endtask

  task automatic sample_rd(input logic [1:0] a);
    bus_if.ADD_I = a;
    #1;
    obs_val.push_back(bus_if.DAT_O);
  endtask

  task automatic sample_req();
    obs_val.push_back(32'(INT_REQ));
  endtask

  task automatic sample_epc();
    obs_val.push_back(EPC_O);
  endtask

  task automatic test_reset();
    logic [31:0] o, e;
    string t;
    RST_I = 1'b0; HWINT = '0; INT_ACK = 1'b0; PC_I = '0; ERET = 1'b0;
    bus_if.ADD_I = 2'd0; bus_if.WE_I = 1'b0; bus_if.DAT_I = '0;
    repeat (3) @(posedge CLK_I);
    #1;
    RST_I = 1'b1;
    expect_v("reset_sr", 32'h0);       sample_rd(2'd0);
    expect_v("reset_cause", 32'h0);    sample_rd(2'd1);
    expect_v("reset_epc", 32'h0);      sample_rd(2'd2);
    expect_v("reset_prid", 32'h0000_4D49); sample_rd(2'd3);
    expect_v("reset_int_req", 32'h0);  sample_req();
    expect_v("reset_epc_o", 32'h0);    sample_epc();
    while (obs_val.size() > 0) begin
      o = obs_val.pop_front();
      checks++;
      if (exp_val.size() == 0) begin
        failures++; $display("FAIL test_reset unexpected sample got=%h", o);
      end else begin
        t = exp_tag.pop_front(); e = exp_val.pop_front();
        if (o !== e) begin failures++; $display("FAIL %s got=%h exp=%h", t, o, e); end
      end
    end
    if (exp_val.size() != 0) begin
      checks++; failures++; $display("FAIL test_reset missing samples=%0d", exp_val.size());
      exp_val.delete(); exp_tag.delete();
    end
  endtask

  task automatic test_irq_raise();
    logic [31:0] o, e;
    string t;
    bus_write(2'd0, 32'h0000_0401);
    HWINT = 6'b000001;
    expect_v("raise_req_c0", 32'h0);  sample_req();
    tick();
    expect_v("raise_cause", 32'h0000_0400); sample_rd(2'd1);
    expect_v("raise_req_c1", 32'h0);  sample_req();
    tick();
    expect_v("raise_req_c2", 32'h1);  sample_req();
    while (obs_val.size() > 0) begin
      o = obs_val.pop_front();
      checks++;
      if (exp_val.size() == 0) begin
        failures++; $display("FAIL test_irq_raise unexpected sample got=%h", o);
      end else begin
        t = exp_tag.pop_front(); e = exp_val.pop_front();
        if (o !== e) begin failures++; $display("FAIL %s got=%h exp=%h", t, o, e); end
      end
    end
    if (exp_val.size() != 0) begin
      checks++; failures++; $display("FAIL test_irq_raise missing samples=%0d", exp_val.size());
      exp_val.delete(); exp_tag.delete();
    end
  endtask

  task automatic test_ack();
    logic [31:0] o, e;
    string t;
    PC_I = 32'h0000_3007; INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    expect_v("ack_epc_o", 32'h0000_3004); sample_epc();
    expect_v("ack_int_req", 32'h0);       sample_req();
    expect_v("ack_sr", 32'h0000_0403);    sample_rd(2'd0);
    expect_v("ack_epc_rd", 32'h0000_3004); sample_rd(2'd2);
    tick(); tick();
    expect_v("service_hold_req", 32'h0);  sample_req();
    while (obs_val.size() > 0) begin
      o = obs_val.pop_front();
      checks++;
      if (exp_val.size() == 0) begin
        failures++; $display("FAIL test_ack unexpected sample got=%h", o);
      end else begin
        t = exp_tag.pop_front(); e = exp_val.pop_front();
        if (o !== e) begin failures++; $display("FAIL %s got=%h exp=%h", t, o, e); end
      end
    end
    if (exp_val.size() != 0) begin
      checks++; failures++; $display("FAIL test_ack missing samples=%0d", exp_val.size());
      exp_val.delete(); exp_tag.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] o, e;
    string t;
    ERET = 1'b1;
    tick();
    ERET = 1'b0;
    expect_v("eret_sr", 32'h0000_0401); sample_rd(2'd0);
    expect_v("eret_req_c0", 32'h0);     sample_req();
    tick();
    expect_v("eret_req_c1", 32'h1);     sample_req();
    while (obs_val.size() > 0) begin
      o = obs_val.pop_front();
      checks++;
      if (exp_val.size() == 0) begin
        failures++; $display("FAIL test_back_to_back unexpected sample got=%h", o);
      end else begin
        t = exp_tag.pop_front(); e = exp_val.pop_front();
        if (o !== e) begin failures++; $display("FAIL %s got=%h exp=%h", t, o, e); end
      end
    end
    if (exp_val.size() != 0) begin
      checks++; failures++; $display("FAIL test_back_to_back missing samples=%0d", exp_val.size());
      exp_val.delete(); exp_tag.delete();
    end
  endtask

  task automatic test_drop();
    logic [31:0] o, e;
    string t;
    HWINT = '0;
    tick(); tick();
    expect_v("drop_req", 32'h0);           sample_req();
    expect_v("drop_epc_o", 32'h0000_3004); sample_epc();
    tick();
    expect_v("drop_req_idle", 32'h0);      sample_req();
    while (obs_val.size() > 0) begin
      o = obs_val.pop_front();
      checks++;
      if (exp_val.size() == 0) begin
        failures++; $display("FAIL test_drop unexpected sample got=%h", o);
      end else begin
        t = exp_tag.pop_front(); e = exp_val.pop_front();
        if (o !== e) begin failures++; $display("FAIL %s got=%h exp=%h", t, o, e); end
      end
    end
    if (exp_val.size() != 0) begin
      checks++; failures++; $display("FAIL test_drop missing samples=%0d", exp_val.size());
      exp_val.delete(); exp_tag.delete();
    end
  endtask

  task automatic test_masked();
    logic [31:0] o, e;
    string t;
    HWINT = 6'b001000;
    tick();
    expect_v("mask_cause", 32'h0000_2000); sample_rd(2'd1);
    expect_v("mask_req_c1", 32'h0);        sample_req();
    tick();
    expect_v("mask_req_c2", 32'h0);        sample_req();
    bus_write(2'd0, 32'h0000_2001);
    expect_v("unmask_req_c0", 32'h0);      sample_req();
    expect_v("unmask_sr", 32'h0000_2001);  sample_rd(2'd0);
    tick();
    expect_v("unmask_req_c1", 32'h1);      sample_req();
    while (obs_val.size() > 0) begin
      o = obs_val.pop_front();
      checks++;
      if (exp_val.size() == 0) begin
        failures++; $display("FAIL test_masked unexpected sample got=%h", o);
      end else begin
        t = exp_tag.pop_front(); e = exp_val.pop_front();
        if (o !== e) begin failures++; $display("FAIL %s got=%h exp=%h", t, o, e); end
      end
    end
    if (exp_val.size() != 0) begin
      checks++; failures++; $display("FAIL test_masked missing samples=%0d", exp_val.size());
      exp_val.delete(); exp_tag.delete();
    end
  endtask

  task automatic test_priority();
    logic [31:0] o, e;
    string t;
    // ACK with a concurrent SR write: IM/IE from bus, EXL forced
    INT_ACK = 1'b1; PC_I = 32'h0000_5551;
    bus_if.ADD_I = 2'd0; bus_if.WE_I = 1'b1; bus_if.DAT_I = 32'h0000_2401;
    tick();
    INT_ACK = 1'b0; bus_if.WE_I = 1'b0;
    expect_v("ack_srwr_sr", 32'h0000_2403); sample_rd(2'd0);
    expect_v("ack_srwr_epc_o", 32'h0000_5550); sample_epc();
    expect_v("ack_srwr_req", 32'h0);        sample_req();
    // ERET with a concurrent SR write: EXL cleared despite DAT_I[1]
    ERET = 1'b1;
    bus_if.ADD_I = 2'd0; bus_if.WE_I = 1'b1; bus_if.DAT_I = 32'h0000_2003;
    tick();
    ERET = 1'b0; bus_if.WE_I = 1'b0;
    expect_v("eret_srwr_sr", 32'h0000_2001); sample_rd(2'd0);
    expect_v("eret_srwr_req", 32'h0);        sample_req();
    tick();
    expect_v("rereq", 32'h1);                sample_req();
    // ACK with a concurrent EPC write: hardware value wins
    INT_ACK = 1'b1; PC_I = 32'h0000_6008;
    bus_if.ADD_I = 2'd2; bus_if.WE_I = 1'b1; bus_if.DAT_I = 32'hAAAA_AAA8;
    tick();
    INT_ACK = 1'b0; bus_if.WE_I = 1'b0;
    expect_v("ack_epcwr_epc_o", 32'h0000_6008); sample_epc();
    // EPC write during SERVICE, low bits forced to zero
    bus_write(2'd2, 32'h0000_1237);
    expect_v("svc_epcwr_epc_o", 32'h0000_1234); sample_epc();
    expect_v("svc_epcwr_rd", 32'h0000_1234);    sample_rd(2'd2);
    // ACK outside REQ is ignored
    INT_ACK = 1'b1; PC_I = 32'h0000_9990;
    tick();
    INT_ACK = 1'b0;
    expect_v("stray_ack_epc_o", 32'h0000_1234); sample_epc();
    expect_v("stray_ack_sr", 32'h0000_2003);    sample_rd(2'd0);
    expect_v("stray_ack_req", 32'h0);           sample_req();
    while (obs_val.size() > 0) begin
      o = obs_val.pop_front();
      checks++;
      if (exp_val.size() == 0) begin
        failures++; $display("FAIL test_priority unexpected sample got=%h", o);
      end else begin
        t = exp_tag.pop_front(); e = exp_val.pop_front();
        if (o !== e) begin failures++; $display("FAIL %s got=%h exp=%h", t, o, e); end
      end
    end
    if (exp_val.size() != 0) begin
      checks++; failures++; $display("FAIL test_priority missing samples=%0d", exp_val.size());
      exp_val.delete(); exp_tag.delete();
    end
  endtask

  task automatic test_reset_mid_service();
    logic [31:0] o, e;
    string t;
    #2;
    RST_I = 1'b0;
    #1;
    expect_v("rst_mid_req", 32'h0);   sample_req();
    expect_v("rst_mid_epc_o", 32'h0); sample_epc();
    expect_v("rst_mid_sr", 32'h0);    sample_rd(2'd0);
    expect_v("rst_mid_epc", 32'h0);   sample_rd(2'd2);
    RST_I = 1'b1;
    tick(); tick(); tick();
    expect_v("rst_after_req", 32'h0);         sample_req();
    expect_v("rst_after_cause", 32'h0000_2000); sample_rd(2'd1);
    expect_v("rst_after_sr", 32'h0);          sample_rd(2'd0);
    while (obs_val.size() > 0) begin
      o = obs_val.pop_front();
      checks++;
      if (exp_val.size() == 0) begin
        failures++; $display("FAIL test_reset_mid_service unexpected sample got=%h", o);
      end else begin
        t = exp_tag.pop_front(); e = exp_val.pop_front();
        if (o !== e) begin failures++; $display("FAIL %s got=%h exp=%h", t, o, e); end
      end
    end
    if (exp_val.size() != 0) begin
      checks++; failures++; $display("FAIL test_reset_mid_service missing samples=%0d", exp_val.size());
      exp_val.delete(); exp_tag.delete();
    end
  endtask

  task automatic test_eret_outside();
    logic [31:0] o, e;
    string t;
    bus_write(2'd0, 32'h0000_0002);
    expect_v("sw_exl_sr", 32'h0000_0002); sample_rd(2'd0);
    ERET = 1'b1;
    tick();
    ERET = 1'b0;
    expect_v("eret_idle_sr", 32'h0);      sample_rd(2'd0);
    expect_v("eret_idle_req", 32'h0);     sample_req();
    while (obs_val.size() > 0) begin
      o = obs_val.pop_front();
      checks++;
      if (exp_val.size() == 0) begin
        failures++; $display("FAIL test_eret_outside unexpected sample got=%h", o);
      end else begin
        t = exp_tag.pop_front(); e = exp_val.pop_front();
        if (o !== e) begin failures++; $display("FAIL %s got=%h exp=%h", t, o, e); end
      end
    end
    if (exp_val.size() != 0) begin
      checks++; failures++; $display("FAIL test_eret_outside missing samples=%0d", exp_val.size());
      exp_val.delete(); exp_tag.delete();
    end
  endtask

  initial begin
    test_reset();
    test_irq_raise();
    test_ack();
    test_back_to_back();
    test_drop();
    test_masked();
    test_priority();
    test_reset_mid_service();
    test_eret_outside();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
